// File: rtl/cu_dispatch.sv
// rtl/cu_dispatch.sv - command dispatch stage: one-hot channel request, ack wait with timeout
module cu_dispatch #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [1:0] cmd_op,
  output logic [3:0] ch_req,
  output logic [1:0] ch_op,
  input  logic [3:0] ch_ack,
  output logic       done,
  output logic       timeout,
  output logic [3:0] err_vec,
  input  logic       err_clr,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ch_req_q, ch_req_d;
  logic [1:0]    ch_op_q, ch_op_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [3:0]    err_q, err_d;
  logic          rdy_q, rdy_d;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    ch_req_d  = ch_req_q;
    ch_op_d   = ch_op_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    rdy_d     = rdy_q;
    // A same-cycle error set overrides the clear for its own bit only
    err_d     = err_clr ? 4'b0000 : err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q && (cmd_op != 2'b00)) begin
          ch_d     = cmd_ch;
          ch_req_d = 4'b0001 << cmd_ch;
          ch_op_d  = cmd_op;
          rdy_d    = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds
        if (ch_ack[ch_q]) begin
          ch_req_d = 4'b0000;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == LAST) begin
          ch_req_d    = 4'b0000;
          timeout_d   = 1'b1;
          err_d[ch_q] = 1'b1;
          rdy_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= 2'b00;
      cnt_q     <= '0;
      ch_req_q  <= 4'b0000;
      ch_op_q   <= 2'b00;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 4'b0000;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      ch_req_q  <= ch_req_d;
      ch_op_q   <= ch_op_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign ch_req    = ch_req_q;
  assign ch_op     = ch_op_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err_vec   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cu_dispatch.sv
// tb/tb_cu_dispatch.sv - directed self-checking bench for cu_dispatch
module tb_cu_dispatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = 2'b00;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] ch_req;
  logic [1:0] ch_op;
  logic [3:0] ch_ack = 4'b0000;
  logic       done;
  logic       timeout;
  logic [3:0] err_vec;
  logic       err_clr = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  cu_dispatch #(.TIMEOUT(15), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .ch_req(ch_req), .ch_op(ch_op), .ch_ack(ch_ack),
    .done(done), .timeout(timeout), .err_vec(err_vec), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one command for a single edge; returns sampled in the ISSUE cycle
  task automatic issue(input logic [1:0] ch, input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  // Counts cycles ch_req stays at pat (bounded), leaves bench at first cycle it drops
  task automatic count_req(input logic [3:0] pat, output int n, output int dones);
    n = 0;
    dones = 0;
    while (ch_req == pat && n < 40) begin
      if (done) dones++;
      n++;
      step();
    end
  endtask

  int n, dones, bad_pulses;

  initial begin
    // 1: reset with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_ch    = 2'b10;
    repeat (3) step();
    check("rst_ready", cmd_ready, 1);
    check("rst_req", ch_req, 4'b0000);
    check("rst_op", ch_op, 2'b00);
    check("rst_flags", {done, timeout, busy}, 3'b000);
    check("rst_err", err_vec, 4'b0000);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    rst_n     = 1'b1;
    step();

    // 2: write to ch2, ack sampled at end of 3rd WAIT cycle
    issue(2'd2, 2'b01);
    check("wr_req", ch_req, 4'b0100);
    check("wr_op", ch_op, 2'b01);
    check("wr_ready_low", {cmd_ready, busy}, 2'b01);
    step();
    step();
    step();
    check("wr_no_done_yet", done, 0);
    ch_ack = 4'b0100;
    step();
    ch_ack = 4'b0000;
    check("wr_done", {done, timeout}, 2'b10);
    check("wr_req_drop", ch_req, 4'b0000);
    step();
    check("wr_done_pulse", done, 0);
    check("wr_ready_back", {cmd_ready, busy}, 2'b10);
    check("wr_err", err_vec, 4'b0000);

    // 3: read to ch1, no ack -> 1 ISSUE + 15 WAIT cycles of request
    issue(2'd1, 2'b10);
    count_req(4'b0010, n, dones);
    check("rd_req_cycles", n, 16);
    check("rd_timeout", {timeout, done}, 2'b10);
    check("rd_err", err_vec, 4'b0010);
    check("rd_idle", {cmd_ready, busy}, 2'b10);
    step();
    check("rd_timeout_pulse", timeout, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("rd_err_clr", err_vec, 4'b0000);

    // 4: foreign ack on ch3 while ch0 waits
    ch_ack = 4'b1000;
    issue(2'd0, 2'b11);
    check("ch0_op", ch_op, 2'b11);
    count_req(4'b0001, n, dones);
    ch_ack = 4'b0000;
    check("ch0_req_cycles", n, 16);
    check("ch0_no_done", dones, 0);
    check("ch0_timeout", timeout, 1);
    check("ch0_err", err_vec, 4'b0001);
    step();

    // 5: ack on the final WAIT cycle wins over timeout
    issue(2'd3, 2'b01);
    repeat (15) step();
    check("last_req_held", ch_req, 4'b1000);
    ch_ack = 4'b1000;
    step();
    ch_ack = 4'b0000;
    check("last_done", {done, timeout}, 2'b10);
    check("last_err", err_vec, 4'b0001);
    step();
    // nop: accepted, no request, stays idle
    issue(2'd2, 2'b00);
    check("nop_idle", {cmd_ready, busy}, 2'b10);
    check("nop_req", ch_req, 4'b0000);
    step();
    check("nop_flags", {done, timeout, busy}, 3'b000);

    // 6: async reset during WAIT on ch3
    issue(2'd3, 2'b10);
    step();
    step();
    check("mid_req", ch_req, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", ch_req, 4'b0000);
    check("async_state", {cmd_ready, busy}, 2'b10);
    step();
    rst_n = 1'b1;
    bad_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || timeout) bad_pulses++;
    end
    check("post_rst_pulses", bad_pulses, 0);
    check("post_rst_idle", {cmd_ready, busy, ch_req}, 6'b100000);
    check("post_rst_err", err_vec, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_dispatch.md
Name: cu_dispatch

Overview:
- Sequential dispatch stage directly downstream of the combinational control decoder.
- Accepts one decoded command per handshake: a target channel (2-bit select, one-hot expanded to 4 channels) and an operation class (write / read / config).
- Drives a request to exactly one channel and waits for that channel's acknowledge, bounded by a timeout.
- Reports completion or timeout and keeps a sticky per-channel error vector for the status path.

Parameters:
- TIMEOUT, 15, cycles in WAIT before the command is abandoned; legal range 1..255.
- CW, 8, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  decoder presents a command.
- cmd_ready  output  1  block can accept a command.
- cmd_ch  input  2  target channel select (00..11).
- cmd_op  input  2  01=write, 10=read, 11=config, 00=nop.
- ch_req  output  4  one-hot request to channels.
- ch_op  output  2  registered op accompanying ch_req.
- ch_ack  input  4  per-channel acknowledge, level-sampled.
- done  output  1  one-cycle pulse on successful completion.
- timeout  output  1  one-cycle pulse on abandonment.
- err_vec  output  4  sticky per-channel timeout flags.
- err_clr  input  1  synchronous clear of err_vec.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) values: cmd_ready=1, ch_req=0, ch_op=0, done=0, timeout=0, err_vec=0, busy=0, FSM=IDLE, counter=0.
- Handshake: a command is accepted on a rising edge where cmd_valid & cmd_ready. cmd_ready=1 only in IDLE (registered).
- A nop command (cmd_op=00) is accepted, stays in IDLE, and produces no req, no done and no timeout.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE -> ISSUE on acceptance of a non-nop command. The block latches ch and op; cmd_ready falls the next cycle.
- ISSUE, one cycle:
  - ch_req[ch]=1 and ch_op=op, both registered, visible the cycle after acceptance.
  - counter is loaded with 0.
  - -> WAIT.
- WAIT:
  - ch_req is held.
  - Each cycle the block samples ch_ack[ch]. Acks on other channels are ignored.
  - ack=1 -> DONE.
  - Otherwise, if counter == TIMEOUT-1: ch_req drops, err_vec[ch] sets, timeout pulses, -> IDLE.
  - Otherwise counter increments.
- ack vs. timeout on the same cycle: ack takes priority, giving success with no error.
- DONE, one cycle: ch_req=0, done=1, -> IDLE. cmd_ready returns the following cycle.
- Latency: acceptance edge -> ch_req high 1 cycle later. Ack sampled -> done high 1 cycle later. Minimum 4 cycles between accepted non-nop commands.
- An ack already high when ISSUE is entered counts in the first WAIT cycle.
- err_clr clears err_vec.
  - If err_clr and a new error set land on the same cycle, the set wins for that bit; all other bits clear.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); the in-flight command is discarded and produces no done or timeout.
- The counter saturates logically at TIMEOUT-1 and never wraps.
- Exactly one ch_req bit is high at any time, or none.

Test Plan:
1. Reset with cmd_valid=1 -> all outputs at reset values, cmd_ready=1; nothing is accepted while rst_n=0.
2. Write to ch 2, ack after 3 WAIT cycles:
   - ch_req=0100 and ch_op=01 one cycle after acceptance.
   - done pulses one cycle after the ack is sampled.
   - err_vec stays 0000; cmd_ready returns.
3. Read to ch 1, ack never arrives, TIMEOUT=15:
   - ch_req=0010 held for 15 WAIT cycles, then drops.
   - timeout pulses once; err_vec=0010.
   - Then err_clr -> err_vec=0000.
4. Ack on ch 3 while ch 0 is in WAIT -> ignored; ch 0 still times out; err_vec=0001.
5. Ack arriving exactly on the last WAIT cycle -> done=1, timeout=0, err_vec unchanged. Nop command -> accepted, no req, busy stays 0.
6. rst_n asserted during WAIT (ch_req=1000) -> ch_req=0000 asynchronously. After release the block is in IDLE with cmd_ready=1, and no done or timeout is ever emitted for the discarded command.
